// File: rtl/arb_pkg.sv
// Shared types for the 4-channel round-robin arbiter.
package arb_pkg;
    localparam int N_CH = 4;
    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         ptr,
    output logic            any,
    output ch_idx_t         grant
);
    logic [N_CH-1:0] rot;
    ch_idx_t         offset;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
            assign rot[gi] = req[ch_idx_t'(ptr + ch_idx_t'(gi))];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = ch_idx_t'(k);
            end
        end
    end

    assign any   = |req;
    assign grant = ch_idx_t'(ptr + offset);
endmodule

// File: rtl/arb_rr_4_1.sv
// Round-robin arbiter feeding a registered 4:1 selector; out_sel drives the
// select of a downstream data mux.
module arb_rr_4_1
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  in_valid,
    output logic [N_CH-1:0]  in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);
    ch_idx_t          ptr_reg;
    ch_idx_t          grant;
    logic             any;
    logic             load;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    ch_idx_t          out_sel_reg;
    logic [WIDTH-1:0] sel_data;

    rr_pick_4 u_pick (
        .req   (in_valid),
        .ptr   (ptr_reg),
        .any   (any),
        .grant (grant)
    );

    // Output register is empty or being drained this cycle.
    assign load = !out_valid_reg || out_ready;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign in_ready[gi] = !rst && load && any && (grant == ch_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        sel_data = in_data0;
        if (grant == 2'd0) begin
            sel_data = in_data0;
        end else if (grant == 2'd1) begin
            sel_data = in_data1;
        end else if (grant == 2'd2) begin
            sel_data = in_data2;
        end else begin
            sel_data = in_data3;
        end
    end

    // Priority only rotates on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            ptr_reg       <= '0;
        end else if (load) begin
            if (any) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sel_data;
                out_sel_reg   <= grant;
                ptr_reg       <= ch_idx_t'(grant + 2'd1);
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
endmodule

// File: tb/tb_arb_rr_4_1.sv
// Self-checking bench for arb_rr_4_1: behavioural priority model plus an
// output scoreboard, with scenario tasks adding directed checks.
module tb_arb_rr_4_1;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } exp_t;

    exp_t       q[$];
    logic [1:0] mptr;
    int         total = 0;
    int         bad = 0;

    arb_rr_4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] chan_data(int i);
        case (i)
            0:       return in_data0;
            1:       return in_data1;
            2:       return in_data2;
            default: return in_data3;
        endcase
    endfunction

    // One clock: predict in_ready, check outputs against the scoreboard head,
    // then advance the model across the rising edge.
    task automatic cycle();
        logic       ld;
        logic [3:0] er;
        int         g;
        exp_t       e;
        #1;
        ld = (q.size() == 0) || out_ready;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && in_valid[(int'(mptr) + k) % 4]) g = (int'(mptr) + k) % 4;
        end
        er = 4'b0000;
        if (!rst && ld && g >= 0) er[g] = 1'b1;
        total++;
        if (in_ready !== er) begin
            bad++;
            $display("FAIL in_ready got=%b exp=%b", in_ready, er);
        end
        if (!rst) begin
            total++;
            if (out_valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL out_valid got=%b exp=%b", out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if (out_data !== q[0].data || out_sel !== q[0].sel) begin
                    bad++;
                    $display("FAIL scoreboard got data=%h sel=%0d exp data=%h sel=%0d",
                             out_data, out_sel, q[0].data, q[0].sel);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            mptr = 2'd0;
        end else if (ld) begin
            if (q.size() != 0) begin
                e = q.pop_front();
                $display("xfer out sel=%0d data=%h", e.sel, e.data);
            end
            if (g >= 0) begin
                q.push_back('{data: chan_data(g), sel: 2'(g)});
                mptr = 2'(g + 1);
            end
        end
        #1;
    endtask

    task automatic check_out(string name, logic [1:0] es, logic [WIDTH-1:0] ed);
        total++;
        if (out_valid !== 1'b1 || out_sel !== es || out_data !== ed) begin
            bad++;
            $display("FAIL %s got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                     name, out_valid, out_sel, out_data, es, ed);
        end
    endtask

    task automatic drain();
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b data=%h sel=%0d exp 0/0/0",
                     out_valid, out_data, out_sel);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL idle_after_reset got v=%b rdy=%b exp 0/0000", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_all_four();
        logic [1:0]       es[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [WIDTH-1:0] ed[5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_out($sformatf("rr_order[%0d]", i), es[i], ed[i]);
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_data1 = 4'h5; in_data2 = 4'h9;
        in_valid = 4'b0110; out_ready = 1'b1;
        cycle();
        check_out("bp_first", 2'd1, 4'h5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_out("bp_hold", 2'd1, 4'h5);
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready got=%b exp=0000", in_ready);
            end
        end
        out_ready = 1'b1;
        cycle();
        check_out("bp_release", 2'd2, 4'h9);
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        in_data0 = 4'h1; in_data1 = 4'h2; in_data2 = 4'h3; in_data3 = 4'h4;
        out_ready = 1'b1;
        in_valid = 4'b0100;
        cycle();
        check_out("wrap_pre", 2'd2, 4'h3);
        in_valid = 4'b1000;
        cycle();
        check_out("wrap_g3", 2'd3, 4'h4);
        in_valid = 4'b0011;
        cycle();
        check_out("wrap_g0", 2'd0, 4'h1);
        cycle();
        check_out("wrap_g1", 2'd1, 4'h2);
        drain();
    endtask

    task automatic test_idle();
        in_data1 = 4'h6; in_data2 = 4'h7;
        out_ready = 1'b1;
        in_valid = 4'b0010;
        cycle();
        check_out("idle_g1", 2'd1, 4'h6);
        in_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_drop got=%b exp=0", out_valid);
            end
        end
        in_valid = 4'b1111;
        cycle();
        check_out("idle_next", 2'd2, 4'h7);
        drain();
    endtask

    task automatic test_reset_stall();
        in_data0 = 4'hE; in_data3 = 4'h8;
        in_valid = 4'b1111; out_ready = 1'b1;
        cycle();
        check_out("rs_load", 2'd3, 4'h8);
        out_ready = 1'b0;
        cycle();
        check_out("rs_stall", 2'd3, 4'h8);
        do_reset();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rs_cleared got v=%b exp=0", out_valid);
        end
        out_ready = 1'b1;
        cycle();
        check_out("rs_first", 2'd0, 4'hE);
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
        mptr = 2'd0;
        test_reset();
        test_all_four();
        test_backpressure();
        test_wrap();
        test_idle();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
